// File: rtl/execute_sequencer_pkg.sv
// Shared types and execute-state codes for the PIC16C5x instruction-cycle sequencer.
package execute_sequencer_pkg;

    localparam int INSTR_WIDTH   = 12;
    localparam int EX_STATE_BITS = 5;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } qphase_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_t;

    localparam logic [EX_STATE_BITS-1:0] EX_Q1        = 5'd0;
    localparam logic [EX_STATE_BITS-1:0] EX_Q2        = 5'd1;
    localparam logic [EX_STATE_BITS-1:0] EX_Q3        = 5'd2;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_NOP    = 5'd3;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_OPTION = 5'd4;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_SLEEP  = 5'd5;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CLRWDT = 5'd6;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_TRIS   = 5'd7;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVWF  = 5'd8;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CLRW   = 5'd9;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CLRF   = 5'd10;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_FSZ    = 5'd11;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVF   = 5'd12;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_BXF    = 5'd13;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_BTFSX  = 5'd14;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_RETLW  = 5'd15;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CALL   = 5'd16;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_GOTO   = 5'd17;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVLW  = 5'd18;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_ALUXLW = 5'd19;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_ELSE   = 5'd20;

endpackage

// File: rtl/execute_sequencer_ex_q4_decode.sv
// Combinational Q4 decoder: instruction register -> execute-state code,
// plus flags for flow-changing and conditional-skip instructions.
module ex_q4_decode
    import execute_sequencer_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0]   i_ir,
    output logic [EX_STATE_BITS-1:0] o_ex_state,
    output logic                     o_is_branch,
    output logic                     o_is_skip_type
);

    always_comb begin
        o_ex_state = EX_Q4_NOP;
        unique case (i_ir[11:8])
            4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
                // Miscellaneous group shares the all-zero byte-op prefix
                if (i_ir[11:5] == 7'b0000000) begin
                    unique case (i_ir[4:0])
                        5'd2:             o_ex_state = EX_Q4_OPTION;
                        5'd3:             o_ex_state = EX_Q4_SLEEP;
                        5'd4:             o_ex_state = EX_Q4_CLRWDT;
                        5'd5, 5'd6, 5'd7: o_ex_state = EX_Q4_TRIS;
                        default:          o_ex_state = EX_Q4_NOP;
                    endcase
                end else if (i_ir[11:5] == 7'b0000001) begin
                    o_ex_state = EX_Q4_MOVWF;
                end else if (i_ir == 12'h040) begin
                    o_ex_state = EX_Q4_CLRW;
                end else if (i_ir[11:5] == 7'b0000011) begin
                    o_ex_state = EX_Q4_CLRF;
                end else if (i_ir[11:6] == 6'b001011 || i_ir[11:6] == 6'b001111) begin
                    o_ex_state = EX_Q4_FSZ;
                end else if (i_ir[11:6] == 6'b001000) begin
                    o_ex_state = EX_Q4_MOVF;
                end else begin
                    o_ex_state = EX_Q4_ELSE;
                end
            end
            4'b0100, 4'b0101: o_ex_state = EX_Q4_BXF;
            4'b0110, 4'b0111: o_ex_state = EX_Q4_BTFSX;
            4'b1000:          o_ex_state = EX_Q4_RETLW;
            4'b1001:          o_ex_state = EX_Q4_CALL;
            4'b1010, 4'b1011: o_ex_state = EX_Q4_GOTO;
            4'b1100:          o_ex_state = EX_Q4_MOVLW;
            default:          o_ex_state = EX_Q4_ALUXLW;
        endcase
    end

    assign o_is_branch    = (o_ex_state == EX_Q4_GOTO) || (o_ex_state == EX_Q4_CALL) ||
                            (o_ex_state == EX_Q4_RETLW);
    assign o_is_skip_type = (o_ex_state == EX_Q4_FSZ) || (o_ex_state == EX_Q4_BTFSX);

endmodule

// File: rtl/execute_sequencer.sv
// Q1-Q4 instruction-cycle sequencer with IR latch, branch/skip flush and
// optional SLEEP halt/wake (enabled by defining EXEC_SLEEP_EN).
module execute_sequencer
    import execute_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTR_WIDTH-1:0]   instrIn,
    input  logic                     skipReq,
    input  logic                     wake,
    output logic [INSTR_WIDTH-1:0]   IR,
    output logic [EX_STATE_BITS-1:0] executeState,
    output logic                     fetchStrobe,
    output logic                     sleeping
);

    qphase_t                  r_q, w_q_nxt;
    logic [INSTR_WIDTH-1:0]   r_ir, w_ir_nxt;
    logic [EX_STATE_BITS-1:0] r_ex, w_ex_nxt;
    logic                     r_fetch, w_fetch_nxt;
    logic [EX_STATE_BITS-1:0] w_dec;
    logic                     w_is_branch;
    logic                     w_is_skip;
    logic                     w_flush;
    logic                     w_halted;

    ex_q4_decode u_decode (
        .i_ir           (r_ir),
        .o_ex_state     (w_dec),
        .o_is_branch    (w_is_branch),
        .o_is_skip_type (w_is_skip)
    );

    // A flushed slot holds IR=0, which decodes as NOP and can never flush again
    assign w_flush = (r_q == Q4) && (w_is_branch || (w_is_skip && skipReq));

`ifdef EXEC_SLEEP_EN
    seq_state_t r_st, w_st_nxt;

    always_comb begin
        w_st_nxt = r_st;
        unique case (r_st)
            ST_RUN:  if (r_q == Q4 && w_dec == EX_Q4_SLEEP) w_st_nxt = ST_HALT;
            ST_HALT: if (wake) w_st_nxt = ST_RUN;
            default: w_st_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_st <= ST_RUN;
        else     r_st <= w_st_nxt;
    end

    assign w_halted = (r_st == ST_HALT);
    assign sleeping = w_halted;
`else
    logic w_unused_wake;
    assign w_unused_wake = wake;
    assign w_halted      = 1'b0;
    assign sleeping      = 1'b0;
`endif

    always_comb begin
        w_q_nxt     = r_q;
        w_ir_nxt    = r_ir;
        w_ex_nxt    = r_ex;
        w_fetch_nxt = 1'b0;
        if (w_halted) begin
            // Wake resumes at Q2 of the instruction latched alongside SLEEP
            if (wake) begin
                w_q_nxt  = Q2;
                w_ex_nxt = EX_Q2;
            end
        end else begin
            unique case (r_q)
                Q1: begin
                    w_q_nxt  = Q2;
                    w_ex_nxt = EX_Q2;
                end
                Q2: begin
                    w_q_nxt  = Q3;
                    w_ex_nxt = EX_Q3;
                end
                Q3: begin
                    w_q_nxt     = Q4;
                    w_ex_nxt    = w_dec;
                    w_fetch_nxt = 1'b1;
                end
                Q4: begin
                    w_q_nxt  = Q1;
                    w_ex_nxt = EX_Q1;
                    w_ir_nxt = w_flush ? '0 : instrIn;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= Q1;
            r_ir    <= '0;
            r_ex    <= EX_Q1;
            r_fetch <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_ir    <= w_ir_nxt;
            r_ex    <= w_ex_nxt;
            r_fetch <= w_fetch_nxt;
        end
    end

    assign IR           = r_ir;
    assign executeState = r_ex;
    assign fetchStrobe  = r_fetch;

endmodule

// File: tb/tb_execute_sequencer.sv
// Scoreboard bench for execute_sequencer: a slot-level reference model queues the
// expected per-clock outputs, and a negedge monitor compares them against the DUT.
module tb_execute_sequencer;
    import execute_sequencer_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [INSTR_WIDTH-1:0]   instrIn;
    logic                     skipReq;
    logic                     wake;
    logic [INSTR_WIDTH-1:0]   IR;
    logic [EX_STATE_BITS-1:0] executeState;
    logic                     fetchStrobe;
    logic                     sleeping;

    execute_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instrIn      (instrIn),
        .skipReq      (skipReq),
        .wake         (wake),
        .IR           (IR),
        .executeState (executeState),
        .fetchStrobe  (fetchStrobe),
        .sleeping     (sleeping)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0]   ir;
        logic [EX_STATE_BITS-1:0] es;
        logic                     fs;
        logic                     sl;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [INSTR_WIDTH-1:0] m_ir;
    bit                     m_halt;

    logic [11:0] special [8] = '{12'hA00, 12'h9F0, 12'h8C3, 12'h2C5,
                                 12'h3E1, 12'h612, 12'h7F3, 12'h003};
    logic [11:0] rows [30] = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005,
                               12'h006, 12'h007, 12'h008, 12'h01F, 12'h025, 12'h040,
                               12'h065, 12'h2C0, 12'h3C0, 12'h200, 12'h1C0, 12'h0A0,
                               12'h4A5, 12'h5A5, 12'h6A5, 12'h7A5, 12'h8A5, 12'h9A5,
                               12'hAA5, 12'hBA5, 12'hCA5, 12'hDA5, 12'hEA5, 12'hFA5};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, req);
    endtask

    // Reference decode straight from the instruction table (first match wins)
    function automatic logic [EX_STATE_BITS-1:0] ref_dec(input logic [11:0] i);
        casez (i)
            12'b0000_0000_0000: return EX_Q4_NOP;
            12'b0000_0000_0010: return EX_Q4_OPTION;
            12'b0000_0000_0011: return EX_Q4_SLEEP;
            12'b0000_0000_0100: return EX_Q4_CLRWDT;
            12'b0000_0000_0101,
            12'b0000_0000_0110,
            12'b0000_0000_0111: return EX_Q4_TRIS;
            12'b0000_0000_????,
            12'b0000_0001_????: return EX_Q4_NOP;
            12'b0000_001?_????: return EX_Q4_MOVWF;
            12'b0000_0100_0000: return EX_Q4_CLRW;
            12'b0000_011?_????: return EX_Q4_CLRF;
            12'b0010_11??_????,
            12'b0011_11??_????: return EX_Q4_FSZ;
            12'b0010_00??_????: return EX_Q4_MOVF;
            12'b00??_????_????: return EX_Q4_ELSE;
            12'b010?_????_????: return EX_Q4_BXF;
            12'b011?_????_????: return EX_Q4_BTFSX;
            12'b1000_????_????: return EX_Q4_RETLW;
            12'b1001_????_????: return EX_Q4_CALL;
            12'b101?_????_????: return EX_Q4_GOTO;
            12'b1100_????_????: return EX_Q4_MOVLW;
            default:            return EX_Q4_ALUXLW;
        endcase
    endfunction

    task automatic push(input logic [11:0] ir, input logic [EX_STATE_BITS-1:0] es,
                        input logic fs, input logic sl);
        exp_t e;
        e.ir = ir; e.es = es; e.fs = fs; e.sl = sl;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        m_ir   = '0;
        m_halt = 1'b0;
    endtask

    // One instruction slot: four clocks showing Q1,Q2,Q3 then the decode of m_ir
    task automatic slot(input logic [11:0] nxt, input bit skip, input bit from_q2,
                        input bit rst_q3);
        logic [EX_STATE_BITS-1:0] d;
        logic [EX_STATE_BITS-1:0] ph [3];
        bit flush;
        ph[0] = EX_Q1; ph[1] = EX_Q2; ph[2] = EX_Q3;
        d = ref_dec(m_ir);
        for (int p = (from_q2 ? 1 : 0); p < 4; p++) begin
            push(m_ir, (p == 3) ? d : ph[p], (p == 3), 1'b0);
            instrIn = (p == 3) ? nxt : 12'($urandom);
            skipReq = (p == 3) ? skip : 1'($urandom);
            wake    = (p == 3) ? 1'b1 : 1'($urandom);
            if (p == 2 && rst_q3) begin
                do_reset();
                return;
            end
            @(posedge clk); #1;
        end
        flush = (d == EX_Q4_GOTO || d == EX_Q4_CALL || d == EX_Q4_RETLW) ||
                (skip && (d == EX_Q4_FSZ || d == EX_Q4_BTFSX));
        m_ir = flush ? 12'h000 : nxt;
`ifdef EXEC_SLEEP_EN
        m_halt = (d == EX_Q4_SLEEP);
`endif
    endtask

    task automatic run_halt(input int n, input bit do_rst);
        for (int i = 0; i < n; i++) begin
            push(m_ir, EX_Q1, 1'b0, 1'b1);
            instrIn = 12'($urandom);
            skipReq = 1'($urandom);
            wake    = 1'b0;
            if (i == n - 1) begin
                wake = 1'b1;
                if (do_rst) begin
                    do_reset();
                    return;
                end
            end
            @(posedge clk); #1;
        end
        m_halt = 1'b0;
    endtask

    task automatic step(input logic [11:0] nxt, input bit skip, input int hlen, input bit hrst);
        bit from_q2;
        from_q2 = 1'b0;
        if (m_halt) begin
            run_halt(hlen, hrst);
            from_q2 = !hrst;
        end
        slot(nxt, skip, from_q2, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("IR",           32'(IR),           32'(e.ir));
            chk("executeState", 32'(executeState), 32'(e.es));
            chk("fetchStrobe",  32'(fetchStrobe),  32'(e.fs));
            chk("sleeping",     32'(sleeping),     32'(e.sl));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instrIn = '0; skipReq = 1'b0; wake = 1'b0;
        m_ir = '0; m_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // MOVLW after the reset NOP, then GOTO flush, BTFSS skip / no-skip, ADDWF ignoring skip
        step(12'hC5A, 1'b0, 1, 0);
        step(12'hAA5, 1'b0, 1, 0);
        step(12'h1C0, 1'b0, 1, 0);
        step(12'h705, 1'b0, 1, 0);
        step(12'h1C0, 1'b1, 1, 0);
        step(12'h705, 1'b0, 1, 0);
        step(12'h1C0, 1'b0, 1, 0);
        step(12'h003, 1'b1, 1, 0);
        step(12'hC11, 1'b0, 1, 0);
        step(12'h1C0, 1'b0, 20, 0);
        step(12'h2C0, 1'b0, 20, 0);

        foreach (rows[i]) step(rows[i], 1'b0, 2, 0);

        // Reset in the middle of Q3, then reset while halted
        slot(12'h123, 1'b0, m_halt, 1'b1);
        step(12'h003, 1'b0, 1, 0);
        step(12'hC77, 1'b0, 1, 0);
        step(12'h456, 1'b0, 5, 1);
        step(12'hC33, 1'b0, 3, 0);

        for (int k = 0; k < 300; k++) begin
            logic [11:0] nxt;
            if ($urandom_range(0, 3) == 0) nxt = special[$urandom_range(0, 7)];
            else                           nxt = 12'($urandom_range(0, 4095));
            step(nxt, 1'($urandom), int'($urandom_range(1, 6)), ($urandom_range(0, 15) == 0));
        end

        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
